// File: rtl/ahbl_splitter_n.sv
// ahbl_splitter_n: AHB-Lite one-master to NS-slave splitter with built-in default slave.
//
// Address phase: HADDR's top DEC_BITS bits are compared against per-slave
// bases; the lowest matching slave gets S_HSEL the same cycle.
// Data phase: sel_d remembers the owner and muxes HREADY/HRESP/HRDATA one
// cycle later. Unmapped active transfers get a two-cycle ERROR response
// from the internal default slave, which also counts and logs them.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HADDR, HTRANS        master address phase
//   HREADY, HRESP, HRDATA muxed data-phase response (HREADY also fans out to slaves)
//   S_HSEL               per-slave select, one-hot or zero
//   S_HRDATA, S_HREADYOUT, S_HRESP  packed slave responses (slave i at slice i)
//   ERR_CLR              synchronous clear of ERR_CNT/ERR_ADDR
//   ERR_CNT, ERR_ADDR    saturating decode-error count and last failing address
module ahbl_splitter_n #(
    parameter int                     NS        = 4,
    parameter int                     DEC_BITS  = 8,
    parameter logic [NS*DEC_BITS-1:0] BASES     = {8'h80, 8'h40, 8'h20, 8'h00},
    parameter logic [31:0]            DEF_RDATA = 32'hBADDBEEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    output logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic [NS-1:0]     S_HSEL,
    input  logic [NS*32-1:0]  S_HRDATA,
    input  logic [NS-1:0]     S_HREADYOUT,
    input  logic [NS-1:0]     S_HRESP,
    input  logic              ERR_CLR,
    output logic [15:0]       ERR_CNT,
    output logic [31:0]       ERR_ADDR
);
    typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

    state_t          state;
    logic [NS-1:0]   sel_d;
    logic            dec_err;
    logic            unused_trans;

    // Only HTRANS[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
    assign unused_trans = HTRANS[0];

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        S_HSEL = '0;
        for (int i = NS - 1; i >= 0; i--)
            if (HADDR[31 -: DEC_BITS] == BASES[i*DEC_BITS +: DEC_BITS]) begin
                S_HSEL    = '0;
                S_HSEL[i] = 1'b1;
            end
    end

    // Default-slave states override the slave mux; sel_d is always zero
    // while in ERR1/ERR2 since it was loaded from an empty decode.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = DEF_RDATA;
        for (int i = 0; i < NS; i++)
            if (sel_d[i]) begin
                HREADY = S_HREADYOUT[i];
                HRESP  = S_HRESP[i];
                HRDATA = S_HRDATA[i*32 +: 32];
            end
        if (state != IDLE) begin
            HREADY = (state == ERR2);
            HRESP  = 1'b1;
            HRDATA = DEF_RDATA;
        end
    end

    assign dec_err = HTRANS[1] & HREADY & ~|S_HSEL;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_d <= '0;
        end else if (HREADY) begin
            sel_d <= HTRANS[1] ? S_HSEL : '0;
        end
    end

    // ERR1 always advances; otherwise a decode error (only possible with
    // HREADY high, i.e. IDLE or ERR2) starts a new error response.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= (state == ERR1) ? ERR2 : (dec_err ? ERR1 : IDLE);
        end
    end

    // A coincident error wins over a clear: the cleared count restarts at one.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_CNT  <= '0;
            ERR_ADDR <= '0;
        end else if (dec_err) begin
            ERR_CNT  <= ERR_CLR ? 16'd1 : ((ERR_CNT == 16'hFFFF) ? ERR_CNT : ERR_CNT + 16'd1);
            ERR_ADDR <= HADDR;
        end else if (ERR_CLR) begin
            ERR_CNT  <= '0;
            ERR_ADDR <= '0;
        end
    end
endmodule

// File: tb/tb_ahbl_splitter_n.sv
// tb_ahbl_splitter_n: scoreboard bench for ahbl_splitter_n (default 4-slave and NS=1 builds).
module tb_ahbl_splitter_n;
    localparam logic [31:0] DEF = 32'hBADDBEEF;

    logic         clk = 1'b0;
    logic         rst_n, rst1_n;
    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic         hready, hresp;
    logic [31:0]  hrdata;
    logic [3:0]   s_hsel;
    logic [127:0] s_hrdata;
    logic [3:0]   s_hreadyout, s_hresp;
    logic         err_clr;
    logic [15:0]  err_cnt;
    logic [31:0]  err_addr;

    logic [31:0]  n1_addr;
    logic [1:0]   n1_trans;
    logic         n1_ready, n1_resp;
    logic [31:0]  n1_rdata;
    logic [0:0]   n1_sel;
    logic [31:0]  n1_srdata;
    logic [0:0]   n1_sready, n1_sresp;
    logic         n1_clr;
    logic [15:0]  n1_cnt;
    logic [31:0]  n1_eaddr;

    logic [33:0]  obs, obs1, exp_v;
    logic [33:0]  sbq[$];
    int           nvec = 0;
    int           nmis = 0;

    assign obs  = {hready, hresp, hrdata};
    assign obs1 = {n1_ready, n1_resp, n1_rdata};

    always #5 clk = ~clk;

    ahbl_splitter_n u_dut (
        .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HTRANS(htrans),
        .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp), .S_HSEL(s_hsel),
        .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout), .S_HRESP(s_hresp),
        .ERR_CLR(err_clr), .ERR_CNT(err_cnt), .ERR_ADDR(err_addr)
    );

    ahbl_splitter_n #(.NS(1), .DEC_BITS(4), .BASES(4'hF)) u_n1 (
        .HCLK(clk), .HRESETn(rst1_n), .HADDR(n1_addr), .HTRANS(n1_trans),
        .HREADY(n1_ready), .HRDATA(n1_rdata), .HRESP(n1_resp), .S_HSEL(n1_sel),
        .S_HRDATA(n1_srdata), .S_HREADYOUT(n1_sready), .S_HRESP(n1_sresp),
        .ERR_CLR(n1_clr), .ERR_CNT(n1_cnt), .ERR_ADDR(n1_eaddr)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst1_n = 1'b0;
        haddr = 32'h0; htrans = 2'b00; err_clr = 1'b0;
        s_hrdata = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        s_hreadyout = 4'hF; s_hresp = 4'h0;
        n1_addr = 32'h0; n1_trans = 2'b00; n1_clr = 1'b0;
        n1_srdata = 32'hC0DE_0001; n1_sready = 1'b1; n1_sresp = 1'b0;
        #3;
        nvec++; if (obs !== {2'b10, DEF}) begin nmis++; $display("FAIL reset_out got=%h want=%h", obs, {2'b10, DEF}); end
        nvec++; if (err_cnt !== 16'h0 || err_addr !== 32'h0) begin nmis++; $display("FAIL reset_err got=%h/%h want=0/0", err_cnt, err_addr); end
        nvec++; if (s_hsel !== 4'b0001) begin nmis++; $display("FAIL reset_hsel got=%b want=0001", s_hsel); end
        step(); step();
        rst_n = 1'b1; rst1_n = 1'b1;
        step();
        nvec++; if (obs !== {2'b10, DEF}) begin nmis++; $display("FAIL post_reset_out got=%h want=%h", obs, {2'b10, DEF}); end
    endtask

    task automatic test_select;
        logic [31:0] a[7] = '{32'h8000_0000, 32'h40FF_FFFF, 32'h2000_0010, 32'h00AB_CDEF,
                              32'hFF00_0000, 32'h8100_0000, 32'h1000_0000};
        logic [3:0]  w[7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            haddr = a[i]; htrans = 2'b00;
            #1;
            nvec++; if (s_hsel !== w[i]) begin nmis++; $display("FAIL select[%0d] got=%b want=%b", i, s_hsel, w[i]); end
            step();
            nvec++; if (obs !== {2'b10, DEF}) begin nmis++; $display("FAIL select_idle[%0d] got=%h want=%h", i, obs, {2'b10, DEF}); end
        end
        haddr = 32'h1000_0000; htrans = 2'b01;
        step();
        htrans = 2'b00;
        #1;
        nvec++; if (obs !== {2'b10, DEF} || err_cnt !== 16'h0) begin nmis++; $display("FAIL busy_unmapped got=%h cnt=%h want=%h cnt=0", obs, err_cnt, {2'b10, DEF}); end
    endtask

    task automatic test_stall;
        step();
        haddr = 32'h2000_0010; htrans = 2'b10; s_hreadyout = 4'hF;
        #1;
        nvec++; if (s_hsel !== 4'b0010) begin nmis++; $display("FAIL stall_hsel got=%b want=0010", s_hsel); end
        sbq.push_back({2'b00, 32'hA000_0001});
        sbq.push_back({2'b00, 32'hA000_0001});
        sbq.push_back({2'b10, 32'hA000_0001});
        sbq.push_back({2'b10, DEF});
        for (int k = 0; k < 4; k++) begin
            step();
            htrans = 2'b00;
            s_hreadyout[1] = (k >= 2);
            #1;
            exp_v = sbq.pop_front();
            nvec++; if (obs !== exp_v) begin nmis++; $display("FAIL stall[%0d] got=%h want=%h", k, obs, exp_v); end
        end
        s_hreadyout = 4'hF;
    endtask

    task automatic test_decode_err;
        step();
        haddr = 32'h1000_0000; htrans = 2'b10;
        #1;
        nvec++; if (s_hsel !== 4'b0000) begin nmis++; $display("FAIL err_hsel got=%b want=0000", s_hsel); end
        sbq.push_back({2'b01, DEF});
        sbq.push_back({2'b11, DEF});
        sbq.push_back({2'b10, DEF});
        for (int k = 0; k < 3; k++) begin
            step();
            htrans = 2'b00;
            #1;
            exp_v = sbq.pop_front();
            nvec++; if (obs !== exp_v) begin nmis++; $display("FAIL decode_err[%0d] got=%h want=%h", k, obs, exp_v); end
        end
        nvec++; if (err_cnt !== 16'd1) begin nmis++; $display("FAIL err_cnt got=%h want=0001", err_cnt); end
        nvec++; if (err_addr !== 32'h1000_0000) begin nmis++; $display("FAIL err_addr got=%h want=10000000", err_addr); end
    endtask

    task automatic test_err_clr;
        step();
        err_clr = 1'b1; htrans = 2'b00;
        step();
        err_clr = 1'b0;
        #1;
        nvec++; if (err_cnt !== 16'h0 || err_addr !== 32'h0) begin nmis++; $display("FAIL err_clr got=%h/%h want=0/0", err_cnt, err_addr); end
    endtask

    task automatic test_back_to_back;
        step();
        haddr = 32'h3000_0004; htrans = 2'b10;
        sbq.push_back({2'b01, DEF});
        sbq.push_back({2'b11, DEF});
        sbq.push_back({2'b01, DEF});
        sbq.push_back({2'b11, DEF});
        sbq.push_back({2'b10, DEF});
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 1) haddr = 32'h5000_0000;
            if (k >= 2) htrans = 2'b00;
            #1;
            exp_v = sbq.pop_front();
            nvec++; if (obs !== exp_v) begin nmis++; $display("FAIL b2b[%0d] got=%h want=%h", k, obs, exp_v); end
        end
        nvec++; if (err_cnt !== 16'd2) begin nmis++; $display("FAIL b2b_cnt got=%h want=0002", err_cnt); end
        nvec++; if (err_addr !== 32'h5000_0000) begin nmis++; $display("FAIL b2b_addr got=%h want=50000000", err_addr); end
    endtask

    task automatic test_s0_then_idle;
        step();
        haddr = 32'h0000_1000; htrans = 2'b10;
        #1;
        nvec++; if (s_hsel !== 4'b0001) begin nmis++; $display("FAIL s0_hsel got=%b want=0001", s_hsel); end
        sbq.push_back({2'b11, 32'hA000_0000});
        sbq.push_back({2'b10, DEF});
        sbq.push_back({2'b10, DEF});
        for (int k = 0; k < 3; k++) begin
            step();
            htrans = 2'b00;
            if (k == 0) s_hresp[0] = 1'b1;
            if (k == 1) s_hreadyout[0] = 1'b0;
            #1;
            exp_v = sbq.pop_front();
            nvec++; if (obs !== exp_v) begin nmis++; $display("FAIL s0_idle[%0d] got=%h want=%h", k, obs, exp_v); end
        end
        s_hresp = 4'h0; s_hreadyout = 4'hF;
    endtask

    task automatic test_clr_coincident;
        step();
        haddr = 32'h1234_5678; htrans = 2'b10; err_clr = 1'b1;
        sbq.push_back({2'b01, DEF});
        sbq.push_back({2'b11, DEF});
        sbq.push_back({2'b10, DEF});
        for (int k = 0; k < 3; k++) begin
            step();
            htrans = 2'b00; err_clr = 1'b0;
            #1;
            exp_v = sbq.pop_front();
            nvec++; if (obs !== exp_v) begin nmis++; $display("FAIL clr_coinc[%0d] got=%h want=%h", k, obs, exp_v); end
            if (k == 0) begin
                nvec++; if (err_cnt !== 16'd1 || err_addr !== 32'h1234_5678) begin nmis++; $display("FAIL clr_coinc_cnt got=%h/%h want=0001/12345678", err_cnt, err_addr); end
            end
        end
    endtask

    task automatic test_saturate;
        step();
        force u_dut.ERR_CNT = 16'hFFFE;
        #1;
        release u_dut.ERR_CNT;
        haddr = 32'hE000_0000; htrans = 2'b10;
        sbq.push_back({2'b01, DEF});
        sbq.push_back({2'b11, DEF});
        sbq.push_back({2'b01, DEF});
        sbq.push_back({2'b11, DEF});
        sbq.push_back({2'b10, DEF});
        for (int k = 0; k < 5; k++) begin
            step();
            if (k >= 2) htrans = 2'b00;
            #1;
            exp_v = sbq.pop_front();
            nvec++; if (obs !== exp_v) begin nmis++; $display("FAIL sat[%0d] got=%h want=%h", k, obs, exp_v); end
            if (k == 0 || k == 4) begin
                nvec++; if (err_cnt !== 16'hFFFF) begin nmis++; $display("FAIL sat_cnt[%0d] got=%h want=ffff", k, err_cnt); end
            end
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1;
        nvec++; if (err_cnt !== 16'h0) begin nmis++; $display("FAIL sat_clr got=%h want=0000", err_cnt); end
    endtask

    task automatic test_async_reset;
        step();
        n1_addr = 32'hF123_0000; n1_trans = 2'b10;
        #1;
        nvec++; if (n1_sel !== 1'b1) begin nmis++; $display("FAIL n1_hsel got=%b want=1", n1_sel); end
        step();
        n1_trans = 2'b00;
        #1;
        nvec++; if (obs1 !== {2'b10, 32'hC0DE_0001}) begin nmis++; $display("FAIL n1_data got=%h want=%h", obs1, {2'b10, 32'hC0DE_0001}); end
        n1_addr = 32'h1000_0000; n1_trans = 2'b10;
        step();
        n1_trans = 2'b00;
        #1;
        nvec++; if (obs1 !== {2'b01, DEF}) begin nmis++; $display("FAIL n1_err1 got=%h want=%h", obs1, {2'b01, DEF}); end
        #2;
        rst1_n = 1'b0;
        #1;
        nvec++; if (obs1 !== {2'b10, DEF} || n1_cnt !== 16'h0 || n1_eaddr !== 32'h0) begin nmis++; $display("FAIL n1_async got=%h cnt=%h addr=%h want=%h cnt=0 addr=0", obs1, n1_cnt, n1_eaddr, {2'b10, DEF}); end
        step();
        rst1_n = 1'b1;
        step();
        nvec++; if (obs1 !== {2'b10, DEF}) begin nmis++; $display("FAIL n1_no_err2 got=%h want=%h", obs1, {2'b10, DEF}); end
        n1_addr = 32'h7000_0000; n1_trans = 2'b10;
        sbq.push_back({2'b01, DEF});
        sbq.push_back({2'b11, DEF});
        sbq.push_back({2'b10, DEF});
        for (int k = 0; k < 3; k++) begin
            step();
            n1_trans = 2'b00;
            #1;
            exp_v = sbq.pop_front();
            nvec++; if (obs1 !== exp_v) begin nmis++; $display("FAIL n1_again[%0d] got=%h want=%h", k, obs1, exp_v); end
        end
        nvec++; if (n1_cnt !== 16'd1 || n1_eaddr !== 32'h7000_0000) begin nmis++; $display("FAIL n1_cnt got=%h/%h want=0001/70000000", n1_cnt, n1_eaddr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_select();
        test_stall();
        test_decode_err();
        test_err_clr();
        test_back_to_back();
        test_s0_then_idle();
        test_clr_coincident();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
